// File: rtl/ts_slot_inserter_if.sv
// Stream, insertion-data and status bundle of ts_slot_inserter.
// The producer/stream side uses master; the inserter uses slave.
interface ts_slot_inserter_if #(
    parameter int WORD_SIZE = 8,
    parameter int DEPTH     = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WORD_SIZE-1:0] ts_in;
    logic                 sync;
    logic [WORD_SIZE-1:0] din;
    logic                 din_valid;
    logic                 din_ready;
    logic [WORD_SIZE-1:0] ts_out;
    logic                 sync_out;
    logic                 slot_active;
    logic                 locked;
    logic [LW-1:0]        fifo_level;
    logic                 underrun;

    modport master (
        output ts_in, sync, din, din_valid,
        input  din_ready, ts_out, sync_out, slot_active, locked, fifo_level, underrun
    );

    modport slave (
        input  ts_in, sync, din, din_valid,
        output din_ready, ts_out, sync_out, slot_active, locked, fifo_level, underrun
    );
endinterface

// File: rtl/ts_slot_inserter.sv
// Frame-locked slot inserter: hunt/check/lock flywheel on SYNC, and an
// all-or-nothing replacement of one payload slot per frame from a local FIFO.
module ts_slot_inserter #(
    parameter int WORD_SIZE     = 8,
    parameter int FRAME_LEN     = 10,
    parameter int SLOT_START    = 1,
    parameter int SLOT_LEN      = 2,
    parameter int DEPTH         = 8,
    parameter int LOCK_THRESH   = 2,
    parameter int UNLOCK_THRESH = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    ts_slot_inserter_if.slave io_ts
);
    localparam int PW = $clog2(FRAME_LEN);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(LOCK_THRESH + 2);
    localparam int MW = $clog2(UNLOCK_THRESH + 1);
    localparam int SW = $clog2(SLOT_LEN + 1);

    localparam logic [PW-1:0] POS_LAST  = PW'(FRAME_LEN - 1);
    localparam logic [PW-1:0] POS_SLOT  = PW'(SLOT_START);
    localparam logic [LW-1:0] LVL_SLOT  = LW'(SLOT_LEN);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_THRESH);
    localparam logic [MW-1:0] MISS_DROP = MW'(UNLOCK_THRESH);
    localparam logic [SW-1:0] SLOT_REM  = SW'(SLOT_LEN - 1);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [PW-1:0]        r_pos;
    logic [PW-1:0]        w_pos;
    logic [GW-1:0]        r_good;
    logic [GW-1:0]        w_good;
    logic [GW-1:0]        w_good_inc;
    logic [MW-1:0]        r_miss;
    logic [MW-1:0]        w_miss;
    logic [MW-1:0]        w_miss_inc;
    logic [SW-1:0]        r_slot_rem;
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [LW-1:0]        r_level;
    logic [WORD_SIZE-1:0] r_mem [DEPTH];
    logic [WORD_SIZE-1:0] r_ts_out;
    logic                 r_sync_out;
    logic                 r_slot_active;
    logic                 r_locked;
    logic                 r_underrun;
    logic                 w_expected;
    logic                 w_slot_start;
    logic                 w_slot_take;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_ready;

    // r_pos is the position of the previous word, so the sync slot follows the last word.
    assign w_expected = (r_state != ST_HUNT) && (r_pos == POS_LAST);
    assign w_good_inc = r_good + GW'(1);
    assign w_miss_inc = r_miss + MW'(1);

    // Flywheel next state, position and good/miss counters
    always_comb begin
        w_next_state = r_state;
        w_pos        = (r_pos == POS_LAST) ? '0 : r_pos + PW'(1);
        w_good       = r_good;
        w_miss       = r_miss;
        case (r_state)
            ST_HUNT: begin
                if (io_ts.sync) begin
                    w_next_state = ST_CHECK;
                    w_good       = GW'(1);
                    w_pos        = '0;
                end else begin
                    w_next_state = ST_HUNT;
                end
            end
            ST_CHECK: begin
                if (w_expected) begin
                    if (io_ts.sync) begin
                        w_pos  = '0;
                        w_good = w_good_inc;
                        if (w_good_inc >= GOOD_LOCK) begin
                            w_next_state = ST_LOCK;
                            w_miss       = '0;
                        end else begin
                            w_next_state = ST_CHECK;
                        end
                    end else begin
                        w_next_state = ST_HUNT;
                    end
                end else if (io_ts.sync) begin
                    w_good = GW'(1);
                    w_pos  = '0;
                end else begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_LOCK: begin
                if (w_expected) begin
                    w_pos = '0;
                    if (io_ts.sync) begin
                        w_miss = '0;
                    end else begin
                        w_miss = w_miss_inc;
                        if (w_miss_inc >= MISS_DROP) begin
                            w_next_state = ST_HUNT;
                        end else begin
                            w_next_state = ST_LOCK;
                        end
                    end
                end else begin
                    w_next_state = ST_LOCK;
                end
            end
            default: begin
                w_next_state = ST_HUNT;
                w_pos        = '0;
                w_good       = '0;
                w_miss       = '0;
            end
        endcase
    end

    // The level test uses the registered level, so a same-cycle write cannot satisfy it.
    assign w_slot_start = (r_state == ST_LOCK) && (w_pos == POS_SLOT) && (r_slot_rem == '0);
    assign w_slot_take  = w_slot_start && (r_level >= LVL_SLOT);
    assign w_pop        = w_slot_take || (r_slot_rem != '0);
    assign w_ready      = (r_level < LVL_FULL);
    assign w_push       = io_ts.din_valid && w_ready;

    // Flywheel and slot-progress registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_HUNT;
            r_pos      <= '0;
            r_good     <= '0;
            r_miss     <= '0;
            r_slot_rem <= '0;
        end else begin
            r_state <= w_next_state;
            r_pos   <= w_pos;
            r_good  <= w_good;
            r_miss  <= w_miss;
            if (w_slot_take) begin
                r_slot_rem <= SLOT_REM;
            end else if (r_slot_rem != '0) begin
                r_slot_rem <= r_slot_rem - SW'(1);
            end
        end
    end

    // FIFO pointers and level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= io_ts.din;
    end

    // Registered stream outputs and status
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ts_out      <= '0;
            r_sync_out    <= 1'b0;
            r_slot_active <= 1'b0;
            r_locked      <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_ts_out      <= w_pop ? r_mem[r_rptr] : io_ts.ts_in;
            r_sync_out    <= io_ts.sync;
            r_slot_active <= w_pop;
            r_locked      <= (r_state == ST_LOCK);
            r_underrun    <= w_slot_start && !w_slot_take;
        end
    end

    assign io_ts.ts_out      = r_ts_out;
    assign io_ts.sync_out    = r_sync_out;
    assign io_ts.slot_active = r_slot_active;
    assign io_ts.locked      = r_locked;
    assign io_ts.underrun    = r_underrun;
    assign io_ts.fifo_level  = r_level;
    assign io_ts.din_ready   = w_ready;
endmodule

// File: tb/tb_ts_slot_inserter.sv
// Directed bench for ts_slot_inserter: frames of FF,EE,EE,00x7 with hand-computed
// expected outputs per position, plus FIFO level / ready / acceptance checks.
module tb_ts_slot_inserter;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   n_acc;
    int   push_at;
    logic [7:0] push_word;
    logic [7:0] pq [$];
    logic       last_rdy;
    logic [9:0] frame_rdy;

    ts_slot_inserter_if #(.WORD_SIZE(8), .DEPTH(8)) bus ();

    ts_slot_inserter #(
        .WORD_SIZE(8), .FRAME_LEN(10), .SLOT_START(1), .SLOT_LEN(2),
        .DEPTH(8), .LOCK_THRESH(2), .UNLOCK_THRESH(3)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_ts (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] word_at(input int i);
        if (i == 0)     return 8'hFF;
        else if (i < 3) return 8'hEE;
        else            return 8'h00;
    endfunction

    // One stream word; the producer presents the queue head and drops it once accepted.
    task automatic tick(input logic [7:0] w, input logic s);
        logic acc;
        logic [7:0] dummy;
        bus.ts_in = w;
        bus.sync  = s;
        if (pq.size() > 0) begin
            bus.din_valid = 1'b1;
            bus.din       = pq[0];
        end else begin
            bus.din_valid = 1'b0;
            bus.din       = 8'h00;
        end
        last_rdy = bus.din_ready;
        acc      = bus.din_valid && bus.din_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            dummy = pq.pop_front();
            n_acc++;
        end
    endtask

    task automatic run_frame(input string tag, input logic hdr, input int spur,
                             input logic [7:0] e1, input logic [7:0] e2,
                             input logic [9:0] x_act, input logic [9:0] x_und,
                             input logic [9:0] x_lck);
        logic [9:0] g_act, g_und, g_lck, g_syn, x_syn;
        logic [7:0] w, x_ts;
        g_act = 10'd0; g_und = 10'd0; g_lck = 10'd0; g_syn = 10'd0;
        x_syn = 10'd0;
        x_syn[0] = hdr;
        if (spur > 0) x_syn[spur] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == push_at) pq.push_back(push_word);
            w = word_at(i);
            tick(w, (i == 0) ? hdr : (i == spur));
            frame_rdy[i] = last_rdy;
            g_act[i] = bus.slot_active;
            g_und[i] = bus.underrun;
            g_lck[i] = bus.locked;
            g_syn[i] = bus.sync_out;
            x_ts = !x_act[i] ? w : ((i == 1) ? e1 : e2);
            check_eq($sformatf("%s ts[%0d]", tag, i), 32'(bus.ts_out), 32'(x_ts));
        end
        check_eq({tag, " slot_active"}, 32'(g_act), 32'(x_act));
        check_eq({tag, " underrun"},    32'(g_und), 32'(x_und));
        check_eq({tag, " locked"},      32'(g_lck), 32'(x_lck));
        check_eq({tag, " sync_out"},    32'(g_syn), 32'(x_syn));
        push_at = -1;
    endtask

    task automatic check_level(input string tag, input int exp);
        check_eq({tag, " level"}, 32'(bus.fifo_level), 32'(exp));
    endtask

    initial begin
        n_tests = 0; n_fail = 0; n_acc = 0; push_at = -1; push_word = 8'h00;
        frame_rdy = 10'd0; last_rdy = 1'b0;
        rst = 1'b1;
        bus.ts_in = 8'h00; bus.sync = 1'b0; bus.din = 8'h00; bus.din_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_eq("rst ts_out",   32'(bus.ts_out),      32'd0);
        check_eq("rst locked",   32'(bus.locked),      32'd0);
        check_eq("rst level",    32'(bus.fifo_level),  32'd0);
        check_eq("rst ready",    32'(bus.din_ready),   32'd1);
        check_eq("rst slot",     32'(bus.slot_active), 32'd0);
        rst = 1'b0;

        // Preload two words while hunting, then lock on two frames.
        pq.push_back(8'hA1); pq.push_back(8'hA2);
        for (int k = 0; k < 3; k++) tick(8'h00, 1'b0);
        check_level("preload", 2);
        run_frame("F1", 1'b1, 0, 8'h00, 8'h00, 10'h000, 10'h000, 10'h000);
        run_frame("F2", 1'b1, 0, 8'hA1, 8'hA2, 10'h006, 10'h000, 10'h3FE);
        check_level("F2", 0);

        // One word short -> underrun; a write in the decision cycle does not count.
        pq.push_back(8'hB1);
        run_frame("F3", 1'b1, 0, 8'h00, 8'h00, 10'h000, 10'h002, 10'h3FF);
        check_level("F3", 1);
        push_at = 1; push_word = 8'hC1;
        run_frame("F4", 1'b1, 0, 8'h00, 8'h00, 10'h000, 10'h002, 10'h3FF);
        check_level("F4", 2);
        run_frame("F5", 1'b1, 0, 8'hB1, 8'hC1, 10'h006, 10'h000, 10'h3FF);
        check_level("F5", 0);

        // Nine words offered back to back: eight fit, the ninth waits for a pop.
        for (int k = 0; k < 9; k++) pq.push_back(8'hD1 + 8'(k));
        n_acc = 0;
        run_frame("F6", 1'b1, 0, 8'h00, 8'h00, 10'h000, 10'h002, 10'h3FF);
        check_eq("F6 accepted", 32'(n_acc), 32'd8);
        check_eq("F6 ready",    32'(bus.din_ready), 32'd0);
        check_eq("F6 rdy mask", 32'(frame_rdy), 32'h0FF);
        check_level("F6", 8);
        run_frame("F7", 1'b1, 0, 8'hD1, 8'hD2, 10'h006, 10'h000, 10'h3FF);
        check_eq("F7 accepted", 32'(n_acc), 32'd9);
        check_eq("F7 rdy mask", 32'(frame_rdy), 32'h3FC);
        check_level("F7", 7);
        run_frame("F8",  1'b1, 0, 8'hD3, 8'hD4, 10'h006, 10'h000, 10'h3FF);
        run_frame("F9",  1'b1, 0, 8'hD5, 8'hD6, 10'h006, 10'h000, 10'h3FF);
        run_frame("F10", 1'b1, 0, 8'hD7, 8'hD8, 10'h006, 10'h000, 10'h3FF);
        check_level("F10", 1);

        // Two missing SYNCs are bridged by the flywheel.
        pq.push_back(8'hE1); pq.push_back(8'hF1); pq.push_back(8'hF2);
        run_frame("F11", 1'b0, 0, 8'hD9, 8'hE1, 10'h006, 10'h000, 10'h3FF);
        check_level("F11", 2);
        run_frame("F12", 1'b0, 0, 8'hF1, 8'hF2, 10'h006, 10'h000, 10'h3FF);
        check_level("F12", 0);

        // Spurious SYNC at position 5 is data; alignment is unchanged next frame.
        pq.push_back(8'h61); pq.push_back(8'h62);
        run_frame("F13", 1'b1, 5, 8'h00, 8'h00, 10'h000, 10'h002, 10'h3FF);
        run_frame("F14", 1'b1, 0, 8'h61, 8'h62, 10'h006, 10'h000, 10'h3FF);

        // Three missing SYNCs drop lock.
        run_frame("F15", 1'b0, 0, 8'h00, 8'h00, 10'h000, 10'h002, 10'h3FF);
        run_frame("F16", 1'b0, 0, 8'h00, 8'h00, 10'h000, 10'h002, 10'h3FF);
        run_frame("F17", 1'b0, 0, 8'h00, 8'h00, 10'h000, 10'h000, 10'h001);

        // SYNC 7 words after the first restarts CHECK on the new alignment.
        run_frame("F18", 1'b1, 7, 8'h00, 8'h00, 10'h000, 10'h000, 10'h000);
        for (int k = 0; k < 7; k++) tick(8'h00, 1'b0);
        check_eq("realign locked", 32'(bus.locked), 32'd0);
        run_frame("F19", 1'b1, 0, 8'h00, 8'h00, 10'h000, 10'h002, 10'h3FE);

        // Reset in the middle of a slot.
        pq.push_back(8'h71); pq.push_back(8'h72);
        run_frame("F20", 1'b1, 0, 8'h00, 8'h00, 10'h000, 10'h002, 10'h3FF);
        check_level("F20", 2);
        tick(8'hFF, 1'b1);
        tick(8'hEE, 1'b0);
        check_eq("mid slot active", 32'(bus.slot_active), 32'd1);
        check_eq("mid slot ts",     32'(bus.ts_out),      32'h71);
        #2 rst = 1'b1;
        #1;
        check_eq("async ts_out",  32'(bus.ts_out),      32'd0);
        check_eq("async sync",    32'(bus.sync_out),    32'd0);
        check_eq("async slot",    32'(bus.slot_active), 32'd0);
        check_eq("async locked",  32'(bus.locked),      32'd0);
        check_eq("async und",     32'(bus.underrun),    32'd0);
        check_eq("async level",   32'(bus.fifo_level),  32'd0);
        check_eq("async ready",   32'(bus.din_ready),   32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        run_frame("R1", 1'b1, 0, 8'h00, 8'h00, 10'h000, 10'h000, 10'h000);
        run_frame("R2", 1'b1, 0, 8'h00, 8'h00, 10'h000, 10'h002, 10'h3FE);
        check_level("R2", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
